bit_sequencer: RTL

//   Upstream driver for the 7-to-1 bit selector. Captures a 7-bit pattern on a load pulse,

---
 rtl/bit_sequencer_if.sv | 20 ++
 rtl/bit_sequencer.sv | 91 +++++++++
 2 files changed

// File: rtl/bit_sequencer_if.sv
// Handshake bundle between a pattern source and bit_sequencer.
// The master side drives load/pattern; the sequencer (slave) returns sel and status.
interface bit_sequencer_if;
   logic       load;
   logic [6:0] pattern;
   logic [2:0] sel;
   logic       bit_out;
   logic       busy;
   logic       done;

   modport master (
      output load, pattern,
      input  sel, bit_out, busy, done
   );

   modport slave (
      input  load, pattern,
      output sel, bit_out, busy, done
   );
endinterface

// File: rtl/bit_sequencer.sv
// Serialises a captured 7-bit pattern one bit every BIT_PERIOD clocks, exporting the mux select.
// Optional feature macro: LOOP_EN (repeat the captured pattern forever instead of single-shot).
module bit_sequencer #(
   parameter int unsigned BIT_PERIOD = 25_000_000,
   parameter int unsigned CNT_W      = 25
) (
   input  logic           clock,
   input  logic           resetn,
   bit_sequencer_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(BIT_PERIOD - 1);
   localparam logic [2:0]       LAST_SEL = 3'd6;

   state_t           state_q;
   logic [6:0]       pattern_q;
   logic [2:0]       sel_q;
   logic [CNT_W-1:0] cnt_q;
   logic             bit_q;
   logic             busy_q;
   logic             done_q;

   logic [2:0]       sel_inc;
   assign sel_inc = sel_q + 3'd1;

   // bit_q is loaded with the bit that the new sel will point at, so it stays registered
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         pattern_q <= '0;
         sel_q     <= '0;
         cnt_q     <= '0;
         bit_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.load) begin
                  pattern_q <= bus.pattern;
                  sel_q     <= '0;
                  cnt_q     <= RELOAD;
                  bit_q     <= bus.pattern[0];
                  busy_q    <= 1'b1;
                  state_q   <= SHIFT;
               end
            end
            SHIFT: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else if (sel_q != LAST_SEL) begin
                  sel_q <= sel_inc;
                  cnt_q <= RELOAD;
                  bit_q <= pattern_q[sel_inc];
               end else begin
`ifdef LOOP_EN
                  sel_q  <= '0;
                  cnt_q  <= RELOAD;
                  bit_q  <= pattern_q[0];
                  done_q <= 1'b1;
`else
                  sel_q   <= '0;
                  bit_q   <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
`endif
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               sel_q   <= '0;
               bit_q   <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.sel     = sel_q;
   assign bus.bit_out = bit_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;

endmodule
